// File: rtl/pic_pkg.sv
// pic_pkg: constants and types shared by the interrupt controller blocks
// (request register, priority resolver, control logic).
package pic_pkg;
    localparam int   NUM_IRQ    = 8;
    localparam int   IRQ_IDX_W  = 3;
    localparam logic LTIM_EDGE  = 1'b0;
    localparam logic LTIM_LEVEL = 1'b1;
    typedef logic [NUM_IRQ-1:0] irq_vec_t;
endpackage

// File: rtl/irq_line_cell.sv
// irq_line_cell: one IR line - input synchroniser, edge history flop and latched request.
// Clears on acknowledge; an init pulse drops the request and re-arms the edge history.
module irq_line_cell
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ir,
    input  logic i_ltim,
    input  logic i_init,
    input  logic i_clr,
    output logic o_raw
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_raw;
    logic                   w_s;
    logic                   w_raw_next;

    assign w_s = r_sync[SYNC_STAGES-1];
    // Edge mode holds a request only while the line stays high; after a clear it waits for a new edge.
    always_comb w_raw_next = (i_init || i_clr) ? 1'b0 :
                             (i_ltim == LTIM_LEVEL) ? w_s : w_s & (~r_prev | r_raw);

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_raw  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ir};
            r_prev <= w_s;
            r_raw  <= w_raw_next;
        end

    assign o_raw = r_raw;
endmodule

// File: rtl/interrupt_request_register.sv
// interrupt_request_register: captures the IR lines, applies the mask and presents a
// freeze-able request vector to the priority resolver, plus the unmasked IRR for read-back.
module interrupt_request_register
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_IRQ-1:0]   i_ir_in,
    input  logic                 i_ltim,
    input  logic                 i_icw1_write,
    input  logic [NUM_IRQ-1:0]   i_imr,
    input  logic                 i_freezing,
    input  logic                 i_clear_irr,
    input  logic [IRQ_IDX_W-1:0] i_clear_index,
    output logic [NUM_IRQ-1:0]   o_irr_reg,
    output logic [NUM_IRQ-1:0]   o_irr_raw
);
    logic     r_ltim;
    irq_vec_t r_irr_reg;
    irq_vec_t w_raw;
    irq_vec_t w_clr;
    logic     w_init;

    always_comb w_clr = i_clear_irr ? irq_vec_t'(1) << i_clear_index : '0;
    // A trigger-mode change outside initialisation re-arms the lines just like an ICW1 write.
    assign w_init = i_icw1_write | (i_ltim != r_ltim);

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_line_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_ir    (i_ir_in[i]),
            .i_ltim  (i_ltim),
            .i_init  (w_init),
            .i_clr   (w_clr[i]),
            .o_raw   (w_raw[i])
        );
    end

    // While frozen only acknowledges may change irr_reg, so the resolver never re-selects a serviced line.
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_ltim    <= LTIM_EDGE;
            r_irr_reg <= '0;
        end else begin
            r_ltim    <= i_ltim;
            r_irr_reg <= i_icw1_write ? '0 : i_freezing ? r_irr_reg & ~w_clr : w_raw & ~i_imr;
        end

    assign o_irr_reg = r_irr_reg;
    assign o_irr_raw = w_raw;
endmodule

// File: tb/tb_interrupt_request_register.sv
// tb_interrupt_request_register: scoreboard bench; each scenario drives per-cycle rows and
// compares irr_reg/irr_raw against the expectation queued when the row was driven.
module tb_interrupt_request_register;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir_in = '0;
    logic       ltim = 1'b0;
    logic       icw1_write = 1'b0;
    logic [7:0] imr = '0;
    logic       freezing = 1'b0;
    logic       clear_irr = 1'b0;
    logic [2:0] clear_index = '0;
    logic [7:0] irr_reg;
    logic [7:0] irr_raw;

    typedef struct packed {
        logic [7:0] ir, imr;
        logic       ltim, init, frz, clr;
        logic [2:0] idx;
        logic [7:0] er, ew;
    } row_t;
    typedef struct {
        string      nm;
        logic [7:0] er, ew;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    interrupt_request_register #(.SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ir_in       (ir_in),
        .i_ltim        (ltim),
        .i_icw1_write  (icw1_write),
        .i_imr         (imr),
        .i_freezing    (freezing),
        .i_clear_irr   (clear_irr),
        .i_clear_index (clear_index),
        .o_irr_reg     (irr_reg),
        .o_irr_raw     (irr_raw)
    );

    always #5 clk = ~clk;

    function automatic row_t R(input int ir, imr, lt, init, frz, clr, idx, er, ew);
        row_t r;
        r.ir = ir[7:0]; r.imr = imr[7:0]; r.ltim = lt[0]; r.init = init[0];
        r.frz = frz[0]; r.clr = clr[0]; r.idx = idx[2:0]; r.er = er[7:0]; r.ew = ew[7:0];
        return r;
    endfunction

    task automatic drive(input string nm, input row_t r);
        exp_t e;
        ir_in = r.ir; imr = r.imr; ltim = r.ltim; icw1_write = r.init;
        freezing = r.frz; clear_irr = r.clr; clear_index = r.idx;
        e.nm = nm; e.er = r.er; e.ew = r.ew;
        q.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        drive("reset", R(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        e = q.pop_front();
        total++;
        if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
            bad++;
            $display("FAIL %s: irr_reg=%h irr_raw=%h want %h %h", e.nm, irr_reg, irr_raw, e.er, e.ew);
        end
        reset = 1'b0;
    endtask

    task automatic test_edge;
        row_t rows [10];
        exp_t e;
        rows = '{R('h08,0,0,0,0,0,0,0,0), R('h08,0,0,0,0,0,0,0,0), R('h08,0,0,0,0,0,0,0,'h08),
                 R('h08,0,0,0,0,0,0,'h08,'h08), R('h08,0,0,0,0,1,3,'h08,0), R('h08,0,0,0,0,0,0,0,0),
                 R('h08,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive("edge", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    task automatic test_level;
        row_t rows [11];
        exp_t e;
        rows = '{R('h20,0,1,0,0,0,0,0,0), R('h20,0,1,0,0,0,0,0,0), R('h20,0,1,0,0,0,0,0,'h20),
                 R('h20,0,1,0,0,0,0,'h20,'h20), R('h20,0,1,0,0,1,5,'h20,0), R('h20,0,1,0,0,0,0,0,'h20),
                 R('h20,0,1,0,0,0,0,'h20,'h20), R(0,0,1,0,0,0,0,'h20,'h20), R(0,0,1,0,0,0,0,'h20,'h20),
                 R(0,0,1,0,0,0,0,'h20,0), R(0,0,1,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive("level", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    task automatic test_mask;
        row_t rows [10];
        exp_t e;
        rows = '{R('h04,'h04,0,0,0,0,0,0,0), R('h04,'h04,0,0,0,0,0,0,0), R('h04,'h04,0,0,0,0,0,0,'h04),
                 R('h04,'h04,0,0,0,0,0,0,'h04), R('h04,0,0,0,0,0,0,'h04,'h04), R('h04,0,0,0,0,1,2,'h04,0),
                 R('h04,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive("mask", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    task automatic test_freeze;
        row_t rows [17];
        exp_t e;
        rows = '{R('h01,0,0,0,0,0,0,0,0), R('h01,0,0,0,0,0,0,0,0), R('h01,0,0,0,0,0,0,0,'h01),
                 R('h01,0,0,0,0,0,0,'h01,'h01), R('h81,0,0,0,1,0,0,'h01,'h01), R('h81,0,0,0,1,0,0,'h01,'h01),
                 R('h81,0,0,0,1,0,0,'h01,'h81), R('h81,0,0,0,1,0,0,'h01,'h81), R('h81,0,0,0,0,0,0,'h81,'h81),
                 R('h81,0,0,0,1,0,0,'h81,'h81), R('h81,0,0,0,1,1,7,'h01,'h01), R('h81,0,0,0,0,0,0,'h01,'h01),
                 R('h81,0,0,0,0,1,0,'h01,0), R('h81,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0),
                 R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive("freeze", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    task automatic test_collision;
        row_t rows [17];
        exp_t e;
        rows = '{R('h10,0,0,0,0,0,0,0,0), R('h10,0,0,0,0,0,0,0,0), R('h10,0,0,0,0,1,4,0,0),
                 R('h10,0,0,0,0,0,0,0,0), R('h10,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0),
                 R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0), R('h10,0,0,0,0,0,0,0,0),
                 R('h10,0,0,0,0,0,0,0,0), R('h10,0,0,0,0,1,1,0,'h10), R('h10,0,0,0,0,0,0,'h10,'h10),
                 R('h10,0,0,0,0,1,4,'h10,0), R('h10,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0),
                 R(0,0,0,0,0,0,0,0,0), R(0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive("collision", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    task automatic test_reset_init;
        row_t pre [3];
        row_t rows [19];
        exp_t e;
        pre = '{R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,'h02)};
        foreach (pre[i]) begin
            drive("pre_reset", pre[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
        #2 reset = 1'b1;
        drive("async_reset", R('h02,0,0,0,0,0,0,0,0));
        #1;
        e = q.pop_front();
        total++;
        if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
            bad++;
            $display("FAIL %s: irr_reg=%h irr_raw=%h want %h %h", e.nm, irr_reg, irr_raw, e.er, e.ew);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rows = '{R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,'h02),
                 R('h02,0,0,0,0,0,0,'h02,'h02), R('h03,0,0,0,0,0,0,'h02,'h02), R('h03,0,0,0,0,0,0,'h02,'h02),
                 R('h03,0,0,0,0,0,0,'h02,'h03), R('h03,0,0,0,0,0,0,'h03,'h03), R('h03,0,0,1,0,0,0,0,0),
                 R('h03,0,0,0,0,0,0,0,0), R('h03,0,0,0,0,0,0,0,0), R('h03,0,0,0,0,0,0,0,0),
                 R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,0), R('h02,0,0,0,0,0,0,0,0),
                 R('h03,0,0,0,0,0,0,0,0), R('h03,0,0,0,0,0,0,0,0), R('h03,0,0,0,0,0,0,0,'h01),
                 R('h03,0,0,0,0,0,0,'h01,'h01)};
        foreach (rows[i]) begin
            drive("init", rows[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if ({irr_reg, irr_raw} !== {e.er, e.ew}) begin
                bad++;
                $display("FAIL %s row %0d: irr_reg=%h irr_raw=%h want %h %h", e.nm, i, irr_reg, irr_raw, e.er, e.ew);
            end
        end
    endtask

    initial begin
        test_reset;
        test_edge;
        test_level;
        test_mask;
        test_freeze;
        test_collision;
        test_reset_init;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
